sl_core_mem_resp: RTL and testbench
===================================

# sl_core_mem_resp

Parametrised memory-backed responder for the core request bus (val/cop/size/addr/wdata in, ack/ack_data out). It generalises the fixed 32-bit core bus to configurable address width, data width and memory depth. It adds programmable ack latency, sub-word lane handling, error signalling and protocol checking. It sits on the slave side of a core's instruction or data port, in block-level benches and in FPGA bring-up builds.

## Interface
Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width; legal values 32 or 64
- DEPTH, 1024, memory depth in DATA_W words; power of two
- LAT_W, 4, width of the latency configuration input

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- req_val  in  1  request valid; held until ack
- req_cop  in  3  operation code; see package
- req_size  in  3  access size code (log2 bytes)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data, right-justified
- lat_cfg  in  LAT_W  extra wait cycles before ack; sampled at accept
- req_ack  out  1  one-cycle completion pulse
- req_ack_data  out  DATA_W  read data, right-justified, zero-extended; valid only with req_ack
- req_err  out  1  qualifies req_ack: request was illegal, no effect
- proto_err  out  1  sticky protocol-violation flag
- busy  out  1  a request is accepted and not yet acked

## Operation
- Reset values: req_ack=0, req_ack_data=0, req_err=0, proto_err=0, busy=0, FSM=IDLE. Memory contents are not reset and persist across reset.
- FSM states:
  - IDLE: on req_val=1, capture cop/size/addr/wdata and load cnt=lat_cfg. Go to ACK if lat_cfg==0, else to WAIT.
  - WAIT: decrement cnt; when cnt==1, go to ACK.
  - ACK: drive req_ack=1 for exactly one cycle, then go to IDLE. There is always at least one IDLE cycle between acks.
- cop decode: COP_RD=3'b000, COP_WR=3'b001; all other codes are illegal.
- size decode:
  - 0 = byte, 1 = half, 2 = word, 3 = dword.
  - size 3 is legal only when DATA_W=64; other sizes are illegal.
- Misalignment: addr[size-1:0] != 0 is an error.
- Illegal cop, illegal size or misalignment gives req_ack=1 with req_err=1, req_ack_data=0, and no memory write.
- Indexing: word index = addr[log2(DATA_W/8)+:log2(DEPTH)]. Higher address bits are ignored, so accesses wrap modulo the memory size.
- Lane offset = addr[log2(DATA_W/8)-1:0].
- Write: the byte enables cover 2^size bytes starting at the lane offset. wdata is shifted left by offset×8. The write commits on the edge that leaves ACK.
- Read: the word is read in ACK, shifted right by offset×8 and masked to 2^size bytes.
- Read after write to the same address, in the next transaction, returns the new data.
- Protocol check: while busy and req_val=1, any change of cop/size/addr/wdata sets proto_err (sticky until reset). req_val dropping before ack also sets proto_err. The captured request still completes normally.

## Timing
- Accept edge A: the posedge where the FSM is in IDLE and req_val=1.
- req_ack is high in the cycle after edge A+lat_cfg. Minimum latency is one cycle; maximum is 2^LAT_W-1 extra cycles.
- busy is high from the cycle after A through the ack cycle inclusive.
- The master must deassert req_val, or present a new request, in the cycle after ack. A request held through the mandatory IDLE cycle is accepted as a new request.
- lat_cfg changes take effect only at the next accept.
- Reset mid-operation (WAIT or ACK) aborts the request. No write is performed and no ack is issued; outputs take their reset values asynchronously.

## Structure
- Package sl_core_pkg: COP_RD, COP_WR, SIZE_B/H/W/D, FSM state enum, helper functions for lane mask and alignment check.
- Sub-module sl_core_mem: DEPTH×DATA_W single-port RAM with byte enables and a synchronous write, combinational read.
- The top holds the FSM, capture registers, latency counter, decode and protocol checker.

## Test plan
- Word write then read, DATA_W=32, lat_cfg=0: WR addr 0x10 data 0xDEADBEEF, then RD 0x10 -> each ack arrives 1 cycle after accept, read returns 0xDEADBEEF with req_err=0.
- Sub-word lanes:
  - WR byte 0xAA to 0x13 over word 0x11223344 at 0x10.
  - RD word 0x10 -> 0xAA223344.
  - RD half 0x12 -> 0x0000AA22.
- Latency and wrap, lat_cfg=5, DEPTH=1024:
  - WR 0x1000 data 0x5A5A5A5A -> ack 6 cycles after accept.
  - RD 0x0000 -> 0x5A5A5A5A (aliases index 0).
- Errors, each giving req_err=1, data 0 and memory unchanged:
  - RD half at 0x11 (misaligned).
  - cop=3'b101 (illegal cop).
  - size=3 with DATA_W=32 (illegal size).
- Protocol violation: change req_addr during WAIT -> proto_err=1 and stays 1. The ack still returns data for the originally captured address.
- Reset during WAIT of a WR to 0x20 (old value 0x0): assert rst low -> req_ack never pulses, busy=0; after release, RD 0x20 returns 0x0.

Source files
------------

// File: rtl/sl_core_pkg.sv
// Shared decode constants, FSM encoding and lane/alignment helpers for the
// memory-backed core bus responder.
package sl_core_pkg;

  localparam logic [2:0] COP_RD = 3'b000;
  localparam logic [2:0] COP_WR = 3'b001;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  // Byte lane idx is enabled when it lies in [off, off + 2^size).
  function automatic logic lane_en(input logic [2:0] size, input logic [2:0] off,
                                   input logic [2:0] idx);
    logic [8:0] lo, hi, b;
    lo = {6'd0, off};
    b  = {6'd0, idx};
    hi = lo + (9'd1 << size);
    return (b >= lo) && (b < hi);
  endfunction

  function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] lo);
    case (size)
      SIZE_B:  return 1'b1;
      SIZE_H:  return lo[0] == 1'b0;
      SIZE_W:  return lo[1:0] == 2'b00;
      default: return lo == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sl_core_mem.sv
// Single-port RAM with byte enables: synchronous write, combinational read.
// Contents are deliberately not reset.
module sl_core_mem #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int NB     = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/sl_core_mem_resp.sv
// Memory-backed slave for the core request bus: captures a request, waits
// lat_cfg cycles, then acks with read data or an error; flags protocol abuse.
module sl_core_mem_resp
  import sl_core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int LAT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_val,
  input  logic [2:0]        req_cop,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LAT_W-1:0]  lat_cfg,
  output logic              req_ack,
  output logic [DATA_W-1:0] req_ack_data,
  output logic              req_err,
  output logic              proto_err,
  output logic              busy
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  state_e              state_q, state_d;
  logic [2:0]          cop_q, cop_d, size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic                proto_q, proto_d;

  logic [OFF_W-1:0]    off;
  logic                cop_ok, size_ok, err;
  logic [NB-1:0]       be, szm;
  logic [DATA_W-1:0]   be_bits, sz_bits, rd_word, rd_shift, wr_shift;
  logic                mem_we;

  // Decode always works on the captured request, never on the live bus.
  assign off     = addr_q[OFF_W-1:0];
  assign cop_ok  = (cop_q == COP_RD) || (cop_q == COP_WR);
  assign size_ok = (size_q <= SIZE_W) || ((size_q == SIZE_D) && (DATA_W == 64));
  assign err     = !cop_ok || !size_ok || !is_aligned(size_q, addr_q[2:0]);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign be[i]              = lane_en(size_q, 3'(off), 3'(i));
    assign szm[i]             = lane_en(size_q, 3'd0, 3'(i));
    assign be_bits[i*8 +: 8]  = {8{be[i]}};
    assign sz_bits[i*8 +: 8]  = {8{szm[i]}};
  end

  assign wr_shift = wdata_q << {off, 3'b000};
  assign rd_shift = (rd_word >> {off, 3'b000}) & sz_bits;
  assign mem_we   = (state_q == ST_ACK) && (cop_q == COP_WR) && !err;

  sl_core_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (be),
    .idx   (addr_q[OFF_W +: IDX_W]),
    .wdata (wr_shift & be_bits),
    .rdata (rd_word)
  );

  always_comb begin
    state_d = state_q;
    cop_d   = cop_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    proto_d = proto_q;
    case (state_q)
      ST_IDLE: begin
        if (req_val) begin
          cop_d   = req_cop;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = lat_cfg;
          state_d = (lat_cfg == '0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_W'(1)) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The master must hold a stable request until ack.
    if ((state_q != ST_IDLE) &&
        (!req_val || (req_cop != cop_q) || (req_size != size_q) ||
         (req_addr != addr_q) || (req_wdata != wdata_q)))
      proto_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cop_q   <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cop_q   <= cop_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      proto_q <= proto_d;
    end
  end

  assign req_ack      = (state_q == ST_ACK);
  assign req_err      = req_ack && err;
  assign req_ack_data = (req_ack && !err && (cop_q == COP_RD)) ? rd_shift : '0;
  assign proto_err    = proto_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sl_core_mem_resp.sv
// Scoreboard bench for sl_core_mem_resp (DATA_W=32, DEPTH=1024, LAT_W=4).
module tb_sl_core_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic [2:0]  req_cop, req_size;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  lat_cfg;
  logic        req_ack, req_err, proto_err, busy;
  logic [31:0] req_ack_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          chk_data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model [1024];

  always #5 clk = ~clk;

  sl_core_mem_resp #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LAT_W(4)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_cop(req_cop), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .lat_cfg(lat_cfg), .req_ack(req_ack),
    .req_ack_data(req_ack_data), .req_err(req_err), .proto_err(proto_err), .busy(busy)
  );

  function automatic logic mdl_err(input logic [2:0] cop, input logic [2:0] size,
                                   input logic [31:0] addr);
    if (cop != 3'b000 && cop != 3'b001) return 1'b1;
    if (size > 3'd2) return 1'b1;
    return (addr % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [2:0] size, input logic [31:0] addr);
    logic [31:0] d, w;
    int off;
    d = '0;
    w = model[addr[11:2]];
    off = int'(addr[1:0]);
    for (int b = 0; b < (1 << size); b++) d[b*8 +: 8] = w[(off+b)*8 +: 8];
    return d;
  endfunction

  task automatic mdl_write(input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd);
    int off;
    off = int'(addr[1:0]);
    for (int b = 0; b < (1 << size); b++) model[addr[11:2]][(off+b)*8 +: 8] = wd[b*8 +: 8];
  endtask

  task automatic drive(input logic [2:0] cop, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] lat);
    exp_t e;
    e.err = mdl_err(cop, size, addr);
    e.lat = int'(lat);
    e.chk_data = (cop == 3'b000) || e.err;
    e.data = (cop == 3'b000 && !e.err) ? mdl_read(size, addr) : 32'h0;
    sb.push_back(e);
    @(negedge clk);
    req_val = 1'b1; req_cop = cop; req_size = size; req_addr = addr; req_wdata = wd;
    lat_cfg = lat;
  endtask

  // Waits for the ack of the request driven last, compares it, then releases the bus.
  task automatic finish_req(input string tag, input logic [2:0] cop, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int n = 0;
    @(posedge clk);
    do begin @(negedge clk); n++; end while (!req_ack && n < 40);
    e = sb.pop_front();
    checks++;
    if (!req_ack) begin
      failures++; $display("FAIL %s ack_timeout got=none want=ack", tag);
    end else begin
      checks++;
      if (n !== e.lat + 1) begin
        failures++; $display("FAIL %s latency got=%0d want=%0d", tag, n, e.lat + 1);
      end
      checks++;
      if (req_err !== e.err) begin
        failures++; $display("FAIL %s req_err got=%b want=%b", tag, req_err, e.err);
      end
      if (e.chk_data) begin
        checks++;
        if (req_ack_data !== e.data) begin
          failures++; $display("FAIL %s data got=%h want=%h", tag, req_ack_data, e.data);
        end
      end
      if (cop == 3'b001 && !e.err) mdl_write(size, addr, wd);
    end
    @(negedge clk);
    checks++;
    if (req_ack !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s post_ack got=ack%b/busy%b want=0/0", tag, req_ack, busy);
    end
    req_val = 1'b0;
  endtask

  task automatic xact(input string tag, input logic [2:0] cop, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] lat);
    drive(cop, size, addr, wd, lat);
    finish_req(tag, cop, size, addr, wd);
  endtask

  task automatic test_reset;
    rst = 1'b0; req_val = 1'b0; req_cop = '0; req_size = '0; req_addr = '0;
    req_wdata = '0; lat_cfg = '0;
    #22;
    checks++;
    if ({req_ack, req_err, proto_err, busy} !== 4'b0 || req_ack_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got=%b%b%b%b/%h want=0000/0", req_ack, req_err, proto_err,
               busy, req_ack_data);
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 16; i++) xact("init", 3'b001, 3'd2, 32'(i*4), 32'h0, 4'd0);
  endtask

  task automatic test_word_rw;
    xact("word_wr", 3'b001, 3'd2, 32'h10, 32'hDEADBEEF, 4'd0);
    xact("word_rd", 3'b000, 3'd2, 32'h10, 32'h0, 4'd0);
  endtask

  task automatic test_lanes;
    xact("lane_wr_word", 3'b001, 3'd2, 32'h10, 32'h11223344, 4'd0);
    xact("lane_wr_byte", 3'b001, 3'd0, 32'h13, 32'h000000AA, 4'd1);
    xact("lane_rd_word", 3'b000, 3'd2, 32'h10, 32'h0, 4'd0);
    xact("lane_rd_half", 3'b000, 3'd1, 32'h12, 32'h0, 4'd2);
    xact("lane_rd_byte", 3'b000, 3'd0, 32'h11, 32'h0, 4'd0);
  endtask

  task automatic test_latency_wrap;
    xact("wrap_wr", 3'b001, 3'd2, 32'h1000, 32'h5A5A5A5A, 4'd5);
    xact("wrap_rd", 3'b000, 3'd2, 32'h0000, 32'h0, 4'd5);
    xact("max_lat", 3'b000, 3'd2, 32'h0004, 32'h0, 4'd15);
  endtask

  task automatic test_errors;
    xact("err_misalign", 3'b000, 3'd1, 32'h11, 32'h0, 4'd0);
    xact("err_cop", 3'b101, 3'd2, 32'h10, 32'hFFFFFFFF, 4'd1);
    xact("err_size", 3'b000, 3'd3, 32'h10, 32'h0, 4'd0);
    xact("err_wr_misalign", 3'b001, 3'd2, 32'h12, 32'hFFFFFFFF, 4'd0);
    xact("err_unchanged", 3'b000, 3'd2, 32'h10, 32'h0, 4'd0);
  endtask

  task automatic test_protocol;
    checks++;
    if (proto_err !== 1'b0) begin
      failures++; $display("FAIL proto_pre got=%b want=0", proto_err);
    end
    drive(3'b000, 3'd2, 32'h10, 32'h0, 4'd3);
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_set got=%b want=1", proto_err);
    end
    begin
      exp_t e;
      int n = 0;
      while (!req_ack && n < 40) begin @(negedge clk); n++; end
      e = sb.pop_front();
      checks++;
      if (!req_ack || req_ack_data !== e.data) begin
        failures++; $display("FAIL proto_data got=%h/ack%b want=%h", req_ack_data, req_ack, e.data);
      end
    end
    @(negedge clk); req_val = 1'b0;
    xact("proto_after", 3'b000, 3'd2, 32'h10, 32'h0, 4'd0);
    checks++;
    if (proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_sticky got=%b want=1", proto_err);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 24; i++) begin
      logic [2:0] sz;
      logic [31:0] a;
      sz = 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3) & ~((1 << sz) - 1));
      xact("b2b", 3'($urandom_range(0, 1)), sz, a, $urandom, 4'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    xact("rst_pre", 3'b001, 3'd2, 32'h20, 32'h0, 4'd0);
    @(negedge clk);
    req_val = 1'b1; req_cop = 3'b001; req_size = 3'd2; req_addr = 32'h20;
    req_wdata = 32'hCAFEF00D; lat_cfg = 4'd5;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || req_ack !== 1'b0 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=busy%b/ack%b/proto%b want=0/0/0", busy, req_ack, proto_err);
    end
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (req_ack) seen = 1; end
    checks++;
    if (seen) begin
      failures++; $display("FAIL rst_mid_ack got=pulse want=none");
    end
    req_val = 1'b0;
    @(negedge clk); rst = 1'b1;
    xact("rst_mid_rd", 3'b000, 3'd2, 32'h20, 32'h0, 4'd0);
  endtask

  initial begin
    test_reset;
    test_word_rw;
    test_lanes;
    test_latency_wrap;
    test_errors;
    test_protocol;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
